// File: rtl/qcv_dmem_pkg.sv
// rtl/qcv_dmem_pkg.sv - shared FSM encodings and LFSR constants for the data memory responder
package qcv_dmem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_GNT_WAIT  = 2'b01,
      ST_RESP_WAIT = 2'b10
   } dmem_state_e;

   // x^8+x^6+x^5+x^4+1 as a Fibonacci shifter: feedback from bits 7,5,4,3
   localparam logic [7:0] LFSR_SEED = 8'hA5;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
      return {cur[6:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/qcv_dmem_sram.sv
// rtl/qcv_dmem_sram.sv - single-port word array, byte-enabled synchronous write, combinational read
module qcv_dmem_sram
   import qcv_dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = 10
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [3:0]    be_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH_WORDS];

   // Byte-lane write; contents are deliberately never reset
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
               mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/qcv_data_mem_resp.sv
// rtl/qcv_data_mem_resp.sv - data memory responder with grant stall and load latency; QCV_DMEM_RANDOM_STALL_EN adds LFSR stalls
module qcv_data_mem_resp
   import qcv_dmem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          GNT_WAIT    = 0,
   parameter int          RVALID_WAIT = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        data_req_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic        data_err_o,
   input  logic [31:0] data_addr_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_wdata_i,
   output logic [31:0] data_rdata_o
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   dmem_state_e state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [3:0]  rcnt_q, rcnt_d;
   logic [31:0] cap_rdata_q, cap_rdata_d;
   logic        cap_err_q, cap_err_d;
   logic [31:0] last_rdata_q, last_rdata_d;
   logic        gnt, rvalid, mem_we;
   logic [31:0] off, mem_rdata;
   logic        in_range;
   logic [4:0]  gnt_target;
   logic        unused_addr_bits;

   assign off      = data_addr_i - BASE_ADDR;
   assign in_range = (data_addr_i >= BASE_ADDR) && ({2'b00, off[31:2]} < 32'(DEPTH_WORDS));
   assign unused_addr_bits = ^{off, data_addr_i[1:0]};

`ifdef QCV_DMEM_RANDOM_STALL_EN
   logic [7:0] lfsr_q;

   // Stall pattern advances once per grant so each request sees a fresh extra delay
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lfsr_q <= LFSR_SEED;
      end else if (gnt) begin
         lfsr_q <= lfsr_next(lfsr_q);
      end
   end

   assign gnt_target = 5'(GNT_WAIT) + {3'b000, lfsr_q[1:0]};
`else
   assign gnt_target = 5'(GNT_WAIT);
`endif

   qcv_dmem_sram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_sram (
      .clk_i   (clk_i),
      .we_i    (mem_we & ~rst_i),
      .be_i    (data_be_i),
      .addr_i  (off[AW+1:2]),
      .wdata_i (data_wdata_i),
      .rdata_o (mem_rdata)
   );

   // State, counters and captured load response
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         rcnt_q       <= '0;
         cap_rdata_q  <= '0;
         cap_err_q    <= 1'b0;
         last_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rcnt_q       <= rcnt_d;
         cap_rdata_q  <= cap_rdata_d;
         cap_err_q    <= cap_err_d;
         last_rdata_q <= last_rdata_d;
      end
   end

   // Grant when the run of request cycles reaches the target; loads then wait out the response latency
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rcnt_d       = rcnt_q;
      cap_rdata_d  = cap_rdata_q;
      cap_err_d    = cap_err_q;
      last_rdata_d = last_rdata_q;
      gnt          = 1'b0;
      rvalid       = 1'b0;
      mem_we       = 1'b0;
      case (state_q)
         ST_IDLE, ST_GNT_WAIT: begin
            if (!data_req_i) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (cnt_q == gnt_target) begin
               gnt   = 1'b1;
               cnt_d = '0;
               if (data_we_i) begin
                  mem_we  = in_range;
                  state_d = ST_IDLE;
               end else begin
                  cap_rdata_d = in_range ? mem_rdata : 32'h0;
                  cap_err_d   = ~in_range;
                  rcnt_d      = 4'd1;
                  state_d     = ST_RESP_WAIT;
               end
            end else begin
               cnt_d   = cnt_q + 5'd1;
               state_d = ST_GNT_WAIT;
            end
         end
         ST_RESP_WAIT: begin
            if (rcnt_q == 4'(RVALID_WAIT)) begin
               rvalid       = 1'b1;
               rcnt_d       = '0;
               last_rdata_d = cap_rdata_q;
               state_d      = ST_IDLE;
            end else begin
               rcnt_d = rcnt_q + 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign data_gnt_o    = gnt & ~rst_i;
   assign data_rvalid_o = rvalid & ~rst_i;
   assign data_err_o    = ~rst_i & ((gnt & data_we_i & ~in_range) | (rvalid & cap_err_q));
   assign data_rdata_o  = rst_i ? 32'h0 : (rvalid ? cap_rdata_q : last_rdata_q);

endmodule

// File: tb/tb_qcv_data_mem_resp.sv
// tb/tb_qcv_data_mem_resp.sv - scoreboard bench for qcv_data_mem_resp with two timing configurations
module tb_qcv_data_mem_resp;

   logic        clk = 1'b0;
   logic        rst;
   logic        req, we;
   logic [31:0] addr, wdata;
   logic [3:0]  be;
   logic        sel;
   logic        req0, req1;
   logic        gnt0, rv0, err0, gnt1, rv1, err1;
   logic [31:0] rd0, rd1;
   logic        mg, mrv, merr;
   logic [31:0] mrd;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   typedef struct { int cyc; logic err; } gnt_exp_t;
   typedef struct { int cyc; logic [31:0] rd; logic err; } rsp_exp_t;
   gnt_exp_t gq[$];
   rsp_exp_t rq[$];
   gnt_exp_t ge;
   rsp_exp_t re;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign req0 = req & ~sel;
   assign req1 = req & sel;
   assign mg   = sel ? gnt1 : gnt0;
   assign mrv  = sel ? rv1  : rv0;
   assign merr = sel ? err1 : err0;
   assign mrd  = sel ? rd1  : rd0;

   qcv_data_mem_resp #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .GNT_WAIT(0), .RVALID_WAIT(1)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .data_req_i(req0), .data_gnt_o(gnt0), .data_rvalid_o(rv0),
      .data_err_o(err0), .data_addr_i(addr), .data_we_i(we), .data_be_i(be),
      .data_wdata_i(wdata), .data_rdata_o(rd0));

   qcv_data_mem_resp #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .GNT_WAIT(3), .RVALID_WAIT(4)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .data_req_i(req1), .data_gnt_o(gnt1), .data_rvalid_o(rv1),
      .data_err_o(err1), .data_addr_i(addr), .data_we_i(we), .data_be_i(be),
      .data_wdata_i(wdata), .data_rdata_o(rd1));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops expectations whenever the selected DUT grants or responds
   always @(negedge clk) begin
      if (!rst) begin
         if (mg) begin
            if (gq.size() == 0) begin
               check("gnt_unexpected", 32'(mg), 32'h0);
            end else begin
               ge = gq.pop_front();
               check("gnt_cycle", cyc, ge.cyc);
               check("gnt_err", 32'(merr), 32'(ge.err));
            end
         end
         if (mrv) begin
            if (rq.size() == 0) begin
               check("rvalid_unexpected", 32'(mrv), 32'h0);
            end else begin
               re = rq.pop_front();
               check("rvalid_cycle", cyc, re.cyc);
               check("rvalid_rdata", mrd, re.rd);
               check("rvalid_err", 32'(merr), 32'(re.err));
            end
         end
         if (!(mg && we) && !mrv) check("err_idle", 32'(merr), 32'h0);
      end
   end

   // One request; stores leave req high so a following request can be back-to-back
   task automatic xact(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err, input bit want_rsp);
      int k, n, gw, rw;
      gw = sel ? 3 : 0;
      rw = sel ? 4 : 1;
      @(posedge clk); #1;
      req = 1'b1; we = w; addr = a; be = b; wdata = d;
      k = cyc;
      gq.push_back('{k + gw, w ? exp_err : 1'b0});
      if (!w && want_rsp) rq.push_back('{k + gw + rw, exp_rd, exp_err});
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mg && n < 40);
      if (!mg) begin
         check("gnt_timeout", 32'h0, 32'h1);
         gq.delete();
         rq.delete();
         req = 1'b0;
         return;
      end
      if (!w) begin
         @(posedge clk); #1;
         req = 1'b0;
         if (want_rsp) begin
            n = 0;
            while (rq.size() != 0 && n < 40) begin
               @(negedge clk);
               n++;
            end
            if (rq.size() != 0) begin
               check("rvalid_timeout", 32'h0, 32'h1);
               rq.delete();
            end
         end
      end
   endtask

   task automatic idle(input int n);
      @(posedge clk); #1;
      req = 1'b0;
      repeat (n) @(posedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; sel = 1'b0; req = 1'b1; we = 1'b0; addr = 32'h0; be = 4'h0; wdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_gnt0", 32'(gnt0), 32'h0);
      check("rst_rv0", 32'(rv0), 32'h0);
      check("rst_err0", 32'(err0), 32'h0);
      check("rst_rd0", rd0, 32'h0);
      check("rst_gnt1", 32'(gnt1), 32'h0);
      check("rst_rd1", rd1, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0; req = 1'b0;
      repeat (2) @(posedge clk);

      // Zero-wait configuration
      xact(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
      xact(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
      xact(1'b1, 32'h10, 4'h4, 32'h00AB0000, 32'h0, 1'b0, 1'b1);
      xact(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEABBEEF, 1'b0, 1'b1);
      xact(1'b1, 32'h14, 4'hF, 32'hAABBCCDD, 32'h0, 1'b0, 1'b1);
      xact(1'b1, 32'h14, 4'h9, 32'h11000022, 32'h0, 1'b0, 1'b1);
      xact(1'b0, 32'h14, 4'h0, 32'h0, 32'h11BBCC22, 1'b0, 1'b1);
      xact(1'b1, 32'h0, 4'hF, 32'h11223344, 32'h0, 1'b0, 1'b1);
      xact(1'b0, 32'h1000, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1);
      xact(1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1);
      xact(1'b0, 32'h0, 4'h0, 32'h0, 32'h11223344, 1'b0, 1'b1);
      idle(3);

      // Stalled configuration
      sel = 1'b1;
      xact(1'b1, 32'h20, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1);
      xact(1'b0, 32'h20, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);

      // Request withdrawn before its grant
      @(posedge clk); #1;
      req = 1'b1; we = 1'b1; addr = 32'h20; be = 4'hF; wdata = 32'h0;
      @(posedge clk); #1;
      req = 1'b0;
      repeat (6) @(posedge clk);
      xact(1'b0, 32'h20, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);

      // Reset while a load is waiting for its response
      xact(1'b0, 32'h20, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("postrst_rvalid", 32'(rv1), 32'h0);
         check("postrst_gnt", 32'(gnt1), 32'h0);
         check("postrst_err", 32'(err1), 32'h0);
         check("postrst_rdata", rd1, 32'h0);
      end
      xact(1'b0, 32'h20, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
      idle(5);
      @(negedge clk);
      check("gnt_queue_drained", gq.size(), 32'h0);
      check("rsp_queue_drained", rq.size(), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
